// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : float_pkg
//  Description : Shared float format helpers: field positions, exponent
//                bias, all-ones exponent constant and converter FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package float_pkg;

    // Default team float format (single precision layout)
    localparam int DEFAULT_MANTISSA_SIZE = 23;
    localparam int DEFAULT_EXPONENT_SIZE = 8;

    // Field positions inside {sign, exponent, mantissa} for the default format
    localparam int MANTISSA_POS = 0;
    localparam int EXPONENT_POS = DEFAULT_MANTISSA_SIZE;
    localparam int SIGN_POS     = DEFAULT_MANTISSA_SIZE + DEFAULT_EXPONENT_SIZE;

    // Exponent value reserved for inf/NaN in the default format
    localparam logic [DEFAULT_EXPONENT_SIZE-1:0] EXP_ALL_ONES = '1;

    // Field positions for an arbitrary format
    function automatic int exponent_pos(input int mantissa_size);
        return mantissa_size;
    endfunction

    function automatic int sign_pos(input int mantissa_size, input int exponent_size);
        return mantissa_size + exponent_size;
    endfunction

    // Exponent bias: 2^(exponent_size-1) - 1
    function automatic int exp_bias(input int exponent_size);
        return (1 << (exponent_size - 1)) - 1;
    endfunction

    // Conversion FSM state encoding
    localparam int          c_ST_W    = 2;
    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_SHIFT = 2'd1;
    localparam logic [1:0]  c_ST_SIGN  = 2'd2;
    localparam logic [1:0]  c_ST_OUT   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/float_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : float_unpack
//  Description : Combinational split of a float word into sign, exponent
//                field, significand with hidden bit, unbiased exponent and
//                class flags (NaN, infinity, zero/denormal).
//  Revision    : 1.0 - initial release
// ============================================================================
module float_unpack
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8
) (
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] i_float,
    output logic                                 o_sign,
    output logic [EXPONENT_SIZE-1:0]             o_exp,
    output logic [MANTISSA_SIZE:0]               o_sig,
    output logic signed [EXPONENT_SIZE:0]        o_exp_unb,
    output logic                                 o_is_nan,
    output logic                                 o_is_inf,
    output logic                                 o_is_zero_or_denorm
);

    localparam int c_BIAS = exp_bias(EXPONENT_SIZE);
    localparam int c_EXP_POS = exponent_pos(MANTISSA_SIZE);
    localparam int c_SIGN_POS = sign_pos(MANTISSA_SIZE, EXPONENT_SIZE);

    logic [MANTISSA_SIZE-1:0] w_man;
    logic                     w_exp_ones;
    logic                     w_exp_zero;

    // Field extraction and classification
    always_comb begin
        o_sign              = i_float[c_SIGN_POS];
        o_exp               = i_float[c_EXP_POS +: EXPONENT_SIZE];
        w_man               = i_float[MANTISSA_SIZE-1:0];
        w_exp_ones          = &o_exp;
        w_exp_zero          = ~|o_exp;
        o_sig               = {~w_exp_zero, w_man};
        o_exp_unb           = $signed({1'b0, o_exp}) - $signed((EXPONENT_SIZE+1)'(c_BIAS));
        o_is_nan            = w_exp_ones & (|w_man);
        o_is_inf            = w_exp_ones & ~(|w_man);
        o_is_zero_or_denorm = w_exp_zero;
    end

endmodule
`default_nettype wire

// File: rtl/float_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : float_to_int
//  Description : Multi-cycle float to two's-complement integer converter.
//                Denormalises the significand by the unbiased exponent in
//                steps of up to SHIFT_STEP bits, truncating toward zero,
//                then applies the sign. Saturates on range overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_to_int
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8,
    parameter int INT_SIZE      = 32,
    parameter int SHIFT_STEP    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] floatIn,
    input  logic                                 floatInValid,
    output logic                                 floatInReady,
    output logic [INT_SIZE-1:0]                  intOut,
    output logic                                 intOutValid,
    input  logic                                 intOutReady,
    output logic                                 overflow
);

    localparam int c_MAG_W   = (INT_SIZE > MANTISSA_SIZE + 1) ? INT_SIZE : MANTISSA_SIZE + 1;
    localparam int c_CNT_W   = $clog2(c_MAG_W + 1);
    localparam int c_STEP    = (SHIFT_STEP < c_MAG_W) ? SHIFT_STEP : c_MAG_W;
    localparam int c_INT_MSB = INT_SIZE - 1;
    // Exponent field value at which the magnitude equals 2^(INT_SIZE-1)
    localparam int c_EXP_INT_MIN = exp_bias(EXPONENT_SIZE) + INT_SIZE - 1;
    localparam logic [INT_SIZE-1:0] c_INT_MAX = {1'b0, {(INT_SIZE-1){1'b1}}};
    localparam logic [INT_SIZE-1:0] c_INT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};

    logic                          w_sign;
    logic [EXPONENT_SIZE-1:0]      w_exp;
    logic [MANTISSA_SIZE:0]        w_sig;
    logic signed [EXPONENT_SIZE:0] w_exp_unb;
    logic                          w_is_nan;
    logic                          w_is_inf;
    logic                          w_is_zd;

    float_unpack #(
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .EXPONENT_SIZE (EXPONENT_SIZE)
    ) u_unpack (
        .i_float             (floatIn),
        .o_sign              (w_sign),
        .o_exp               (w_exp),
        .o_sig               (w_sig),
        .o_exp_unb           (w_exp_unb),
        .o_is_nan            (w_is_nan),
        .o_is_inf            (w_is_inf),
        .o_is_zero_or_denorm (w_is_zd)
    );

    logic [c_ST_W-1:0]   r_state, w_state_nxt;
    logic [c_MAG_W-1:0]  r_mag, w_mag_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic                r_left, w_left_nxt;
    logic                r_sign, w_sign_nxt;
    logic [INT_SIZE-1:0] r_int, w_int_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic                r_valid, w_valid_nxt;

    logic signed [31:0]  w_e_ext;
    logic signed [31:0]  w_diff;
    logic signed [31:0]  w_k;
    logic [c_CNT_W-1:0]  w_step;
    logic [INT_SIZE-1:0] w_mag_low;
    logic                w_exact_min;

    // Next-state and datapath decisions for the conversion FSM
    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_cnt_nxt   = r_cnt;
        w_left_nxt  = r_left;
        w_sign_nxt  = r_sign;
        w_int_nxt   = r_int;
        w_ovf_nxt   = r_ovf;
        w_valid_nxt = r_valid;

        w_e_ext     = 32'(w_exp_unb);
        w_diff      = w_e_ext - MANTISSA_SIZE;
        w_k         = w_diff[31] ? -w_diff : w_diff;
        w_step      = (32'(r_cnt) > c_STEP) ? c_CNT_W'(c_STEP) : r_cnt;
        w_mag_low   = r_mag[INT_SIZE-1:0];
        // Only -2^(INT_SIZE-1) itself lands on the saturation value exactly
        w_exact_min = w_sign && (32'(w_exp) == c_EXP_INT_MIN) && (w_sig[MANTISSA_SIZE-1:0] == '0);

        case (r_state)
            c_ST_IDLE: begin
                if (floatInValid) begin
                    w_sign_nxt = w_sign;
                    if (w_is_nan) begin
                        w_int_nxt   = '0;
                        w_ovf_nxt   = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_OUT;
                    end else if (w_is_inf) begin
                        w_int_nxt   = w_sign ? c_INT_MIN : c_INT_MAX;
                        w_ovf_nxt   = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_OUT;
                    end else if (w_is_zd || w_e_ext < 0) begin
                        w_int_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_OUT;
                    end else if (w_e_ext >= c_INT_MSB) begin
                        w_int_nxt   = w_sign ? c_INT_MIN : c_INT_MAX;
                        w_ovf_nxt   = ~w_exact_min;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_OUT;
                    end else begin
                        w_mag_nxt   = c_MAG_W'(w_sig);
                        w_cnt_nxt   = c_CNT_W'(w_k);
                        w_left_nxt  = ~w_diff[31];
                        w_state_nxt = c_ST_SHIFT;
                    end
                end
            end
            c_ST_SHIFT: begin
                w_mag_nxt = r_left ? (r_mag << w_step) : (r_mag >> w_step);
                w_cnt_nxt = r_cnt - w_step;
                if (w_cnt_nxt == '0) begin
                    w_state_nxt = c_ST_SIGN;
                end
            end
            c_ST_SIGN: begin
                w_int_nxt   = r_sign ? (~w_mag_low + 1'b1) : w_mag_low;
                w_ovf_nxt   = 1'b0;
                w_valid_nxt = 1'b1;
                w_state_nxt = c_ST_OUT;
            end
            default: begin
                if (intOutReady) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_mag   <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_sign  <= 1'b0;
            r_int   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mag   <= w_mag_nxt;
            r_cnt   <= w_cnt_nxt;
            r_left  <= w_left_nxt;
            r_sign  <= w_sign_nxt;
            r_int   <= w_int_nxt;
            r_ovf   <= w_ovf_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign floatInReady = (r_state == c_ST_IDLE);
    assign intOut       = r_int;
    assign intOutValid  = r_valid;
    assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_float_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_to_int
//  Description : Directed self-checking bench for float_to_int.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_to_int;

    logic        clk;
    logic        reset;
    logic [31:0] floatIn;
    logic        floatInValid;
    logic        floatInReady;
    logic [31:0] intOut;
    logic        intOutValid;
    logic        intOutReady;
    logic        overflow;

    int n_checks;
    int n_fail;

    float_to_int #(
        .MANTISSA_SIZE (23),
        .EXPONENT_SIZE (8),
        .INT_SIZE      (32),
        .SHIFT_STEP    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .floatIn      (floatIn),
        .floatInValid (floatInValid),
        .floatInReady (floatInReady),
        .intOut       (intOut),
        .intOutValid  (intOutValid),
        .intOutReady  (intOutReady),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one float, wait for the result, check it, optionally stall
    // the consumer for hold_cycles, then complete the output handshake.
    task automatic convert(input string tag, input logic [31:0] f, input logic [31:0] exp_int,
                           input logic exp_ovf, input int exp_lat, input int hold_cycles);
        int   edges;
        logic ready_seen;
        @(negedge clk);
        check_val({tag, "_ready_idle"}, 64'(floatInReady), 64'd1);
        floatIn      = f;
        floatInValid = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        floatInValid = 1'b0;
        ready_seen   = 1'b0;
        while (!intOutValid && edges < 40) begin
            if (floatInReady) ready_seen = 1'b1;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check_val({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check_val({tag, "_int"}, 64'(intOut), 64'(exp_int));
        check_val({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        check_val({tag, "_ready_busy"}, 64'(ready_seen | floatInReady), 64'd0);
        for (int i = 0; i < hold_cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val({tag, "_hold_valid"}, 64'(intOutValid), 64'd1);
            check_val({tag, "_hold_int"}, 64'(intOut), 64'(exp_int));
            check_val({tag, "_hold_ovf"}, 64'(overflow), 64'(exp_ovf));
            check_val({tag, "_hold_ready"}, 64'(floatInReady), 64'd0);
        end
        intOutReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        intOutReady = 1'b0;
        check_val({tag, "_done_valid"}, 64'(intOutValid), 64'd0);
        check_val({tag, "_done_ready"}, 64'(floatInReady), 64'd1);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        floatIn      = '0;
        floatInValid = 1'b0;
        intOutReady  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check_val("rst_int",   64'(intOut),       64'd0);
        check_val("rst_valid", 64'(intOutValid),  64'd0);
        check_val("rst_ovf",   64'(overflow),     64'd0);
        check_val("rst_ready", 64'(floatInReady), 64'd1);

        convert("one",     32'h3F80_0000, 32'h0000_0001, 1'b0, 5, 0);
        convert("m123",    32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 5, 0);
        convert("big",     32'h4EFF_FFFF, 32'd2147483520, 1'b0, 3, 0);
        convert("p2_31",   32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1, 0);
        convert("m2_31",   32'hCF00_0000, 32'h8000_0000, 1'b0, 1, 0);
        convert("ninf",    32'hFF80_0000, 32'h8000_0000, 1'b1, 1, 0);
        convert("nan",     32'h7FC0_0000, 32'h0000_0000, 1'b1, 1, 0);
        convert("half",    32'h3F00_0000, 32'h0000_0000, 1'b0, 1, 0);
        convert("denorm",  32'h0000_0001, 32'h0000_0000, 1'b0, 1, 0);
        convert("hold",    32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 5, 3);
        convert("after",   32'h4040_0000, 32'h0000_0003, 1'b0, 5, 0);

        // Abort a conversion of 1.0 while it is in the shift phase
        @(negedge clk);
        floatIn      = 32'h3F80_0000;
        floatInValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        floatInValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_valid", 64'(intOutValid),  64'd0);
        check_val("abort_ready", 64'(floatInReady), 64'd1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_val("abort_stale", 64'(intOutValid),  64'd0);

        convert("two",     32'h4000_0000, 32'h0000_0002, 1'b0, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
